// File: rtl/sync_pulse_arbiter.sv
// rtl/sync_pulse_arbiter.sv - round-robin launcher sharing one pulse synchronizer
//
// Purpose: captures single-cycle request pulses from N_REQ requesters into
// sticky pending bits and grants them round-robin. Each grant launches one
// pulse into a shared fast-to-slow pulse synchronizer. The next pulse is not
// launched until the synchronizer acknowledges and a guard gap has passed.
//
// Ports (all in the clka domain):
//   clka           sole clock, rising edge
//   rst            synchronous reset, active-high
//   req_pulse_i    one-cycle request pulse per requester
//   sync_done_i    one-cycle acknowledge returned by the synchronizer
//   sync_pulse_o   registered launch pulse, one cycle per grant
//   sync_id_o      granted requester index, held until the next launch
//   pend_o         pending request bits
//   drop_o         sticky: request arrived while already pending
//   busy_o         high while in ISSUE, WAIT or GAP
//   timeout_err_o  sticky abort flag (constant 0 unless enabled)
//
// Optional feature macro: SYNC_ARB_TIMEOUT_EN enables the WAIT timeout, which
// aborts a launch after TIMEOUT WAIT cycles without an acknowledge.

module sync_pulse_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clka,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse_i,
  input  logic             sync_done_i,
  output logic             sync_pulse_o,
  output logic [ID_W-1:0]  sync_id_o,
  output logic [N_REQ-1:0] pend_o,
  output logic [N_REQ-1:0] drop_o,
  output logic             busy_o,
  output logic             timeout_err_o
);

  if (N_REQ < 2 || N_REQ > 16 || (2 ** ID_W) < N_REQ ||
      GAP_CYC < 1 || GAP_CYC > 15 || TIMEOUT < 8 || TIMEOUT > 1023) begin : g_bad_params
    $error("sync_pulse_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  // The gap counter counts down to 0, so GAP lasts exactly GAP_CYC cycles.
  localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYC - 1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, drop_q, clr_mask;
  logic [ID_W-1:0]  ptr_q, id_q, win_id, hi_id, lo_id;
  logic             hi_found, grant, wait_expired, pulse_q;
  logic [3:0]       gap_q;

  // Round-robin search: the lowest pending index at or above the pointer wins;
  // if none, wrap around to the lowest pending index overall.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_id = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  assign grant    = (state_q == S_IDLE) && (|pend_q);
  assign clr_mask = grant ? (N_REQ'(1) << win_id) : '0;

  // State register
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|pend_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (sync_done_i || wait_expired) state_d = S_GAP;
      S_GAP:   if (gap_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      pend_q  <= '0;
      drop_q  <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      pulse_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      // A grant-edge pulse re-arms the bit instead of counting as a drop.
      pend_q  <= (pend_q & ~clr_mask) | req_pulse_i;
      drop_q  <= drop_q | (req_pulse_i & pend_q & ~clr_mask);
      pulse_q <= (state_d == S_ISSUE);
      if (grant) begin
        id_q  <= win_id;
        ptr_q <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
      end
      if (state_q == S_WAIT && state_d == S_GAP) begin
        gap_q <= GAP_LOAD;
      end else if (state_q == S_GAP && gap_q != 4'd0) begin
        gap_q <= gap_q - 4'd1;
      end
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  logic [9:0] wait_q;
  logic       timeout_q;

  // wait_q counts WAIT cycles already completed; expiry fires on the edge
  // that ends the TIMEOUT-th WAIT cycle. An acknowledge on that edge wins.
  assign wait_expired = (wait_q == 10'(TIMEOUT - 1));

  always_ff @(posedge clka) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q <= (state_q == S_WAIT) ? wait_q + 10'd1 : '0;
      if (state_q == S_WAIT && !sync_done_i && wait_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err_o = timeout_q;
`else
  assign wait_expired  = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign sync_pulse_o = pulse_q;
  assign sync_id_o    = id_q;
  assign pend_o       = pend_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// tb/tb_sync_pulse_arbiter.sv - bench for sync_pulse_arbiter
module tb_sync_pulse_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 8;

  logic             clka;
  logic             rst;
  logic [N_REQ-1:0] req_pulse_i;
  logic             sync_done_i;
  logic             sync_pulse_o;
  logic [ID_W-1:0]  sync_id_o;
  logic [N_REQ-1:0] pend_o;
  logic [N_REQ-1:0] drop_o;
  logic             busy_o;
  logic             timeout_err_o;

  int checks   = 0;
  int failures = 0;
  int launches = 0;
  int cyc      = 0;
  int base;
  logic prev_pulse = 1'b0;
  logic [ID_W-1:0] exp_q[$];
  int launch_cyc[$];

  sync_pulse_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clka(clka),
    .rst(rst),
    .req_pulse_i(req_pulse_i),
    .sync_done_i(sync_done_i),
    .sync_pulse_o(sync_pulse_o),
    .sync_id_o(sync_id_o),
    .pend_o(pend_o),
    .drop_o(drop_o),
    .busy_o(busy_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;
  always @(posedge clka) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every launch must match the oldest expected grant id.
  always @(negedge clka) begin
    if (sync_pulse_o === 1'b1) begin
      launch_cyc.push_back(cyc);
      launches++;
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      chk("launch_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("launch_id", 32'(sync_id_o), 32'(exp_q.pop_front()));
    end
    prev_pulse = sync_pulse_o;
  end

  task automatic wait_launch(input string tag);
    int n = 0;
    do begin
      @(negedge clka);
      req_pulse_i = '0;
      n++;
    end while (sync_pulse_o !== 1'b1 && n < 50);
    chk({tag, "_launch_seen"}, 32'(sync_pulse_o), 32'd1);
  endtask

  task automatic serve_one(input string tag);
    wait_launch(tag);
    @(negedge clka);
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 50) begin
      @(negedge clka);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clka);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    req_pulse_i = '0;
    sync_done_i = 1'b0;
    repeat (2) @(negedge clka);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    chk("rst_pulse", 32'(sync_pulse_o), 32'd0);
    chk("rst_id", 32'(sync_id_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_terr", 32'(timeout_err_o), 32'd0);
    rst = 1'b0;
    @(negedge clka);

    // Single request, cycle-exact latency and gap
    req_pulse_i = 4'b0100;
    exp_q.push_back(2'd2);
    @(negedge clka);
    req_pulse_i = '0;
    chk("single_pend", 32'(pend_o), 32'h4);
    chk("single_pulse_early", 32'(sync_pulse_o), 32'd0);
    @(negedge clka);
    chk("single_pulse", 32'(sync_pulse_o), 32'd1);
    chk("single_id", 32'(sync_id_o), 32'd2);
    chk("single_busy_issue", 32'(busy_o), 32'd1);
    @(negedge clka);
    chk("single_pulse_fall", 32'(sync_pulse_o), 32'd0);
    chk("single_busy_wait", 32'(busy_o), 32'd1);
    repeat (2) @(negedge clka);
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
    chk("single_busy_gap0", 32'(busy_o), 32'd1);
    @(negedge clka);
    chk("single_busy_gap1", 32'(busy_o), 32'd1);
    @(negedge clka);
    chk("single_busy_fall", 32'(busy_o), 32'd0);
    chk("single_id_hold", 32'(sync_id_o), 32'd2);

    // Simultaneous requests after reset: 0,1,2,3 spaced 2+1+GAP_CYC
    do_reset();
    base = launches;
    req_pulse_i = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(ID_W'(i));
    for (int i = 0; i < 4; i++) serve_one("simul");
    wait_idle("simul");
    chk("simul_drop", 32'(drop_o), 32'd0);
    chk("simul_count", 32'(launches - base), 32'd4);
    for (int j = 1; j < 4; j++)
      chk("simul_spacing", 32'(launch_cyc[base + j] - launch_cyc[base + j - 1]), 32'(3 + GAP_CYC));

    // Round-robin: last grant 1, then pend 1011 -> 3,0,1
    req_pulse_i = 4'b0010;
    exp_q.push_back(2'd1);
    serve_one("rr_pre");
    wait_idle("rr_pre");
    req_pulse_i = 4'b1011;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int i = 0; i < 3; i++) serve_one("rr");
    wait_idle("rr");

    // Drop: requester 2 pulsed twice while pending behind requester 0
    req_pulse_i = 4'b0001;
    exp_q.push_back(2'd0);
    wait_launch("drop_a");
    @(negedge clka);
    req_pulse_i = 4'b0100;
    @(negedge clka);
    req_pulse_i = '0;
    @(negedge clka);
    req_pulse_i = 4'b0100;
    @(negedge clka);
    req_pulse_i = '0;
    chk("drop_flag", 32'(drop_o), 32'h4);
    chk("drop_pend", 32'(pend_o), 32'h4);
    exp_q.push_back(2'd2);
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
    serve_one("drop_b");
    wait_idle("drop_b");
    chk("drop_single_launch_q", 32'(exp_q.size()), 32'd0);

    // Pulse on the requester's own grant edge: re-armed, no drop
    req_pulse_i = 4'b0001;
    exp_q.push_back(2'd0);
    @(negedge clka);
    req_pulse_i = 4'b0001;
    exp_q.push_back(2'd0);
    @(negedge clka);
    req_pulse_i = '0;
    chk("regrant_pend", 32'(pend_o), 32'h1);
    chk("regrant_drop", 32'(drop_o), 32'h4);
    chk("regrant_pulse", 32'(sync_pulse_o), 32'd1);
    @(negedge clka);
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
    serve_one("regrant");
    wait_idle("regrant");
    chk("regrant_drop_final", 32'(drop_o), 32'h4);

    // Reset in WAIT, then a late acknowledge
    req_pulse_i = 4'b0010;
    exp_q.push_back(2'd1);
    wait_launch("rstwait");
    @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
    rst = 1'b0;
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
    base = launches;
    repeat (10) @(negedge clka);
    chk("rstwait_pend", 32'(pend_o), 32'd0);
    chk("rstwait_drop", 32'(drop_o), 32'd0);
    chk("rstwait_pulse", 32'(sync_pulse_o), 32'd0);
    chk("rstwait_id", 32'(sync_id_o), 32'd0);
    chk("rstwait_busy", 32'(busy_o), 32'd0);
    chk("rstwait_terr", 32'(timeout_err_o), 32'd0);
    @(posedge clka);
    chk("rstwait_no_launch", 32'(launches - base), 32'd0);
    @(negedge clka);

`ifdef SYNC_ARB_TIMEOUT_EN
    // Timeout after TIMEOUT WAIT cycles, next launch after GAP_CYC
    do_reset();
    base = launches;
    req_pulse_i = 4'b0001;
    exp_q.push_back(2'd0);
    wait_launch("tmo_a");
    @(negedge clka);
    req_pulse_i = 4'b0010;
    exp_q.push_back(2'd1);
    @(negedge clka);
    req_pulse_i = '0;
    repeat (TIMEOUT - 2) @(negedge clka);
    chk("tmo_not_yet", 32'(timeout_err_o), 32'd0);
    @(negedge clka);
    chk("tmo_flag", 32'(timeout_err_o), 32'd1);
    wait_launch("tmo_b");
    chk("tmo_spacing", 32'(launch_cyc[base + 1] - launch_cyc[base]), 32'(2 + TIMEOUT + GAP_CYC));
    @(negedge clka);
    sync_done_i = 1'b1;
    @(negedge clka);
    sync_done_i = 1'b0;
    wait_idle("tmo_b");
    chk("tmo_sticky", 32'(timeout_err_o), 32'd1);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_pulse_arbiter.md
# sync_pulse_arbiter

Source-domain controller that shares one pulse synchronizer (fast clock to slow clock) among `N_REQ` requesters in the `clka` domain. Single-cycle request pulses are captured into sticky pending bits and granted round-robin. Each grant launches exactly one pulse into the synchronizer, then waits for the synchronizer's returned acknowledge plus a guard gap before the next launch. No pulse is ever presented while a previous one is still in flight.

## Interface
- `N_REQ`, 4: number of requesters (2..16)
- `ID_W`, 2: width of grant id; must satisfy 2^`ID_W` >= `N_REQ`
- `GAP_CYC`, 2: idle `clka` cycles enforced after each acknowledge (1..15)
- `TIMEOUT`, 64: max WAIT cycles before abort (8..1023; used only with `SYNC_ARB_TIMEOUT_EN`)

- `clka`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_pulse_i`  in  `N_REQ`  one-cycle request pulse per requester
- `sync_done_i`  in  1  one-cycle acknowledge from the synchronizer, already in `clka` domain
- `sync_pulse_o`  out  1  registered pulse to the synchronizer input, high exactly 1 cycle per grant
- `sync_id_o`  out  `ID_W`  index of the granted requester; held stable from launch until the next launch
- `pend_o`  out  `N_REQ`  pending request bits
- `drop_o`  out  `N_REQ`  sticky flag: a request arrived while that requester was already pending
- `busy_o`  out  1  high in ISSUE, WAIT and GAP
- `timeout_err_o`  out  1  sticky abort flag; constant 0 without the macro

## Operation
- Reset: state IDLE; `pend_o`, `drop_o`, `sync_pulse_o`, `sync_id_o`, `busy_o` and `timeout_err_o` are 0; round-robin pointer set so requester 0 has highest priority.
- Capture: at each edge, `pend[i]` is set by `req_pulse_i[i]`.
  - If `pend[i]` is already 1 and is not being cleared by a grant at this edge, `drop_o[i]` is set. The pulse is merged, not queued.
  - If the grant clears `pend[i]` at the same edge that a new `req_pulse_i[i]` arrives, `pend[i]` stays 1 and no drop is recorded.
- Arbitration: round-robin, searching upward from (last grant + 1) mod `N_REQ`. The winner becomes lowest priority after its grant.
- FSM:
  - IDLE: if `pend` != 0, go to ISSUE. At that same edge: clear the winner's pend bit, load `sync_id_o`, update the pointer.
  - ISSUE: `sync_pulse_o` = 1 for this single cycle. Next state is WAIT, unconditionally.
  - WAIT: on `sync_done_i` = 1, go to GAP and load the gap counter with `GAP_CYC` - 1.
  - GAP: decrement the counter each cycle. At 0, go to IDLE.
- `sync_done_i` is ignored in IDLE, ISSUE and GAP.
- `drop_o` and `timeout_err_o` clear only on `rst`.

## Timing
- Path to launch: request pulse sampled at edge k → `pend` set after k → ISSUE entered at edge k+1 → `sync_pulse_o` high in cycle k+1..k+2. This is 2 cycles of latency when idle.
- Minimum spacing between launches is 2 + W + `GAP_CYC` cycles, where W is the number of cycles spent in WAIT (W >= 1).
- A `sync_done_i` sampled during the single ISSUE cycle is lost, so the synchronizer's acknowledge must arrive no earlier than 1 cycle after `sync_pulse_o` falls.
- Reset mid-operation: at the next edge, all state is cleared. Any in-flight pulse is abandoned, and a late `sync_done_i` is ignored because the FSM is in IDLE.

## Configuration
- `SYNC_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs while in WAIT.
  - If `TIMEOUT` cycles elapse without `sync_done_i`, set `timeout_err_o` and go to GAP, exactly as if the acknowledge had arrived.
  - The granted request is not re-queued.
- `SYNC_ARB_TIMEOUT_EN` undefined:
  - No timeout counter; WAIT persists until `sync_done_i`.
  - `timeout_err_o` is tied to 0.

## Test plan
- Single request: `req_pulse_i`=4'b0100 sampled at edge 10 → `sync_pulse_o` high in cycle 11–12 with `sync_id_o`=2. Drive `sync_done_i` 3 cycles later → `busy_o` falls `GAP_CYC`=2 cycles after the done.
- Simultaneous requests: `req_pulse_i`=4'b1111 for one cycle after reset → grants in order 0,1,2,3. Each launch follows the previous one's done plus the gap, and `drop_o` stays 0.
- Round-robin fairness: last grant 1; `pend`=4'b1011 → next id 3, then 0, then 1.
- Drop: pulse requester 2 twice while it is pending (not yet granted) → `drop_o`=4'b0100 and a single launch with id 2. Also pulse a requester on its own grant edge → no drop, and a second launch follows.
- Reset mid-WAIT: assert `rst` for 1 cycle during WAIT, then pulse `sync_done_i` → all outputs 0 and no further launch.
- With `SYNC_ARB_TIMEOUT_EN` and `TIMEOUT`=8: launch with no `sync_done_i` → `timeout_err_o`=1 after 8 WAIT cycles. The next pending request then launches after `GAP_CYC`.
